bit_serializer: RTL
===================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
- REQ-001: The block SHALL have parameter WIDTH, default 8: number of data bits per word, legal range 1..32.
- REQ-002: The block SHALL have parameter MSB_FIRST, default 1: 1 sends the MSB first, 0 sends the LSB first.
- REQ-003: The block SHALL have port clock, input, 1 bit: the single clock; all state SHALL update on its rising edge.
- REQ-004: The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
- REQ-005: The block SHALL have port in_data, input, WIDTH bits: the parallel word to send.
- REQ-006: The block SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
- REQ-007: The block SHALL have port in_ready, output, 1 bit: the block can accept a word this cycle.
- REQ-008: The block SHALL have port x, output, 1 bit: the serial bit stream fed to the downstream Mealy detector's x input.
- REQ-009: The block SHALL have port x_valid, output, 1 bit: x carries a live bit this cycle.
- REQ-010: The block SHALL have port done, output, 1 bit: a one-cycle pulse marking the final bit of a word.

Function
- REQ-011: The block SHALL implement the states IDLE, SHIFT and PARITY; PARITY exists only per REQ-024.
- REQ-012: in_ready SHALL be 1 exactly when the state is IDLE, combinationally.
- REQ-013: A handshake occurs at a rising edge where in_valid=1 and in_ready=1. At that edge the block SHALL register in_data into the shift register, clear the bit counter, and move to SHIFT.
- REQ-014: If in_valid=1 while the state is not IDLE, the block SHALL ignore it: no latch and no state change.
- REQ-015: In SHIFT, x SHALL be driven from the shift-register bit selected by MSB_FIRST and x_valid SHALL be 1. Each clock edge SHALL shift the register by one and increment the counter.
- REQ-016: The first bit SHALL appear on x in the cycle immediately after the handshake edge.
- REQ-017: Bits SHALL occupy consecutive cycles 1..WIDTH after the handshake, with no gaps.
- REQ-018: done SHALL be 1 only in the cycle carrying the last transmitted bit.
- REQ-019: After the last bit the block SHALL return to IDLE, so there is a minimum of one idle cycle between words.
- REQ-020: In IDLE, x SHALL be 0, x_valid SHALL be 0 and done SHALL be 0.
- REQ-021: The counter SHALL be sized $clog2(WIDTH+1). It SHALL never wrap during a word; WIDTH=1 SHALL produce a single-bit word with done in that same cycle.
- REQ-022: When in_valid is held at 1 continuously, words SHALL be accepted back-to-back, one every WIDTH+1 cycles (WIDTH+2 with parity).

Reset
- REQ-023: When reset=0 at a rising edge, the block SHALL go to IDLE, and outputs SHALL be x=0, x_valid=0, done=0 and in_ready=1 from the next cycle. This SHALL apply in any state, including mid-word: the partial word is discarded and no done pulse is issued. No output SHALL depend on reset asynchronously.

Configuration
- REQ-024: Macro BIT_SERIALIZER_PARITY_EN. When it is defined, the block SHALL insert a PARITY state after the last data bit. In that state x SHALL equal the XOR of all latched data bits (even parity) and x_valid SHALL be 1. done SHALL move from the last data bit to the parity cycle.
- REQ-025: When BIT_SERIALIZER_PARITY_EN is undefined, the block SHALL contain no PARITY state and no parity logic; SHIFT SHALL go directly to IDLE.

Structure
- REQ-026: Package bit_serializer_pkg SHALL hold the state enum (IDLE, SHIFT, PARITY) and the default-WIDTH constant.
- REQ-027: The block SHALL have one sub-module, bit_counter: a loadable up-counter with a terminal-count flag at WIDTH-1, instantiated once.
- REQ-028: The shift register and output muxing SHALL stay in the top module.

Verification
- REQ-029: Scenario, MSB-first word: WIDTH=8, MSB_FIRST=1, handshake with 0xB2. Required response: x = 1,0,1,1,0,0,1,0 in cycles 1..8; x_valid=1 throughout; done=1 in cycle 8 only; in_ready=1 again in cycle 9.
- REQ-030: Scenario, LSB-first word: MSB_FIRST=0, handshake with 0x01. Required response: x = 1 then seven 0s; done in cycle 8.
- REQ-031: Scenario, parity: BIT_SERIALIZER_PARITY_EN defined, send 0xB3 (five ones). Required response: 8 data bits, then x=1 in cycle 9 with done=1; then send 0xB2. Required response: x=0 in the parity cycle.
- REQ-032: Scenario, reset mid-word: assert reset=0 at cycle 4 of a word. Required response: the next cycle shows x=0, x_valid=0, done=0, in_ready=1; no done pulse for that word.
- REQ-033: Scenario, input while busy: pulse in_valid with 0xFF during cycle 3 of a 0x00 word. Required response: x stays 0 for all 8 bits; 0xFF is never transmitted.
- REQ-034: Scenario, back-to-back words: hold in_valid=1 with 0xAA then 0x55. Required response: handshakes 9 cycles apart; x_valid low for exactly one cycle between the words.

Source files
------------

// File: rtl/bit_serializer_pkg.sv
// Shared definitions for bit_serializer: state encoding, default word width
// and the even-parity helper used when BIT_SERIALIZER_PARITY_EN is defined.
package bit_serializer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  function automatic logic even_parity(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/bit_serializer_bit_counter.sv
// bit_counter: loadable up-counter that tracks the bit position within a word
// and flags the terminal count at WIDTH-1.
module bit_counter
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          tc
);

  // Count register: load has priority over increment.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (inc) begin
      count <= count + CW'(1);
    end else begin
      count <= count;
    end
  end

  assign tc = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial converter with registered x/x_valid/done.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit to every word.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam bit DATA_DONE = 1'b0;
`else
  localparam bit DATA_DONE = 1'b1;
`endif

  state_e           state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] shifted_s;
  logic             x_r;
  logic             x_valid_r;
  logic             done_r;
  logic [CW-1:0]    cnt_s;
  logic             tc_s;
  logic             load_s;
  logic             inc_s;
  logic             next_is_last_s;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic             parity_r;
`endif

  function automatic logic pick(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (load_s),
    .load_value ('0),
    .inc        (inc_s),
    .count      (cnt_s),
    .tc         (tc_s)
  );

  // Counter control and the shift-register view of the next bit.
  always_comb begin
    load_s         = 1'b0;
    inc_s          = 1'b0;
    shifted_s      = MSB_FIRST ? (shreg_r << 1'b1) : (shreg_r >> 1'b1);
    next_is_last_s = (cnt_s == CW'(WIDTH - 2));
    if (state_r == IDLE) begin
      load_s = in_valid;
    end else if (state_r == SHIFT) begin
      inc_s = !tc_s;
    end else begin
      inc_s = 1'b0;
    end
  end

  // FSM with outputs registered one step ahead of the bit they describe.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r   <= IDLE;
      shreg_r   <= '0;
      x_r       <= 1'b0;
      x_valid_r <= 1'b0;
      done_r    <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            state_r   <= SHIFT;
            shreg_r   <= in_data;
            x_r       <= pick(in_data);
            x_valid_r <= 1'b1;
            done_r    <= DATA_DONE && (WIDTH == 1);
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_r  <= even_parity(32'(in_data));
`endif
          end else begin
            x_r       <= 1'b0;
            x_valid_r <= 1'b0;
            done_r    <= 1'b0;
          end
        end
        SHIFT: begin
          if (tc_s) begin
`ifdef BIT_SERIALIZER_PARITY_EN
            state_r   <= PARITY;
            x_r       <= parity_r;
            x_valid_r <= 1'b1;
            done_r    <= 1'b1;
`else
            state_r   <= IDLE;
            x_r       <= 1'b0;
            x_valid_r <= 1'b0;
            done_r    <= 1'b0;
`endif
          end else begin
            shreg_r   <= shifted_s;
            x_r       <= pick(shifted_s);
            x_valid_r <= 1'b1;
            done_r    <= DATA_DONE && next_is_last_s;
          end
        end
        default: begin
          // Covers the parity cycle and any illegal encoding.
          state_r   <= IDLE;
          x_r       <= 1'b0;
          x_valid_r <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = (state_r == IDLE);
  assign x        = x_r;
  assign x_valid  = x_valid_r;
  assign done     = done_r;

endmodule
